spi_reg_ctrl: RTL
=================

Name: spi_reg_ctrl

Overview:
- Command/register-file controller behind the SPI slave core. It sits between the slave's byte interface (rx_data/rx_valid/tx_data/tx_req) and fabric logic.
- It frames transactions on spi_cs_n and decodes the first byte as a read/write command with a 7-bit address. It then streams register data in or out with auto-increment.
- Exposes NUM_REGS read/write control registers plus one read-only status input to the fabric.

Parameters:
- DATA_WIDTH, 8, byte width of the SPI slave; must be >= 8. The command uses bit [DATA_WIDTH-1] and bits [6:0].
- NUM_REGS, 8, number of R/W registers at addresses 0..NUM_REGS-1; range 1..126.
- HEADER, 8'hA5, value on tx_data during the command byte; zero-extended to DATA_WIDTH.

Ports:
- clk  in  1  system clock; the SPI slave core runs on the same clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- spi_cs_n  in  1  raw chip select from the pad, active low. Passes through an internal 2-flop synchronizer.
- rx_data  in  DATA_WIDTH  byte received by the SPI slave.
- rx_valid  in  1  one-clk pulse; rx_data is valid in this cycle.
- tx_req  in  1  one-clk pulse when the slave captures tx_data for the next byte (informational; used only by the optional feature).
- tx_data  out  DATA_WIDTH  byte the slave shifts out next.
- reg_out  out  NUM_REGS*DATA_WIDTH  flat register bank; reg k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- wr_stb  out  1  one-clk pulse when a register is written.
- wr_addr  out  7  address written in the wr_stb cycle.
- status_in  in  DATA_WIDTH  read-only value at address 7'h7F, sampled at the moment of load into tx_data.
- err  out  1  sticky flag: illegal access seen in the current or last frame.

Behaviour:
- Reset (rst_n=0 on rising clk): state=IDLE, all regs=0, tx_data=HEADER, wr_stb=0, wr_addr=0, err=0, synchronizer flops=1. The FSM leaves IDLE only on a synchronized cs falling edge, so any frame in progress at reset release is ignored until cs rises.
- Synchronized cs (cs_s) lags the pad by 2 clk. Falling edge = cs_s 1->0; rising edge = cs_s 0->1.
- States:
  - IDLE: on cs falling -> CMD; tx_data<=HEADER; err<=0.
  - CMD: on rx_valid, addr<=rx_data[6:0].
    - If rx_data[DATA_WIDTH-1]=1 (read) -> RD; tx_data<=value(addr) in the next clk.
    - Else -> WR.
  - WR: on rx_valid, if addr<NUM_REGS: reg[addr]<=rx_data, wr_stb=1, wr_addr=addr. Otherwise no write and err<=1. Then addr<=next(addr).
  - RD: on rx_valid (dummy byte, contents ignored): addr<=next(addr); tx_data<=value(next(addr)).
- From any non-IDLE state, cs rising -> IDLE. tx_data<=HEADER on that same transition.
- value(a):
  - a<NUM_REGS: reg[a].
  - a=7'h7F: status_in.
  - Otherwise: 0, and err<=1 (set in the load cycle).
- next(a):
  - a<NUM_REGS-1: a+1.
  - a=NUM_REGS-1: 0 (wrap).
  - a>=NUM_REGS: a unchanged, so repeated illegal accesses stay illegal.
- Latency: tx_data updates exactly 1 clk after the rx_valid cycle. wr_stb, reg_out and wr_addr update in the clk after rx_valid (registered). The slave core guarantees >=4 clk between rx_valid and the next tx_req.
- Simultaneous rx_valid and cs rising edge in one cycle: the byte is processed first (write/read side effects occur), then state=IDLE and tx_data=HEADER. The HEADER load overrides the read load.
- Frame of only the command byte: no writes, no address effect on the next frame.
- rx_valid in IDLE: ignored.
- A cs falling edge while not in IDLE cannot occur (rising always precedes it). The FSM needs no handling for it.

Optional Feature:
- Macro: SPI_REG_CTRL_ERRCNT_EN.
- With the macro: an 8-bit saturating counter (stops at 255) increments once per frame ending (cs rising) with err=1.
  - Readable at address 7'h7E as value(7'h7E), zero-extended.
  - Writing any value to 7'h7E clears it, with no wr_stb.
  - Also counts tx_req pulses seen in IDLE as errors (underrun).
  - Reset value 0.
- Without the macro: 7'h7E behaves as any illegal address (read 0, err set; write ignored, err set).

Test Plan:
- Reset then frame {8'h02, 8'h11, 8'h22}: reg2=8'h11, reg3=8'h22; two wr_stb pulses with wr_addr 2 then 3. MISO bytes: A5, then don't-care, then don't-care.
- Frame {8'h82, 8'h00, 8'h00, 8'h00} after the previous write: tx_data sequence HEADER(A5), 11, 22, reg4=00. tx_data updates 1 clk after each rx_valid.
- NUM_REGS=8, write frame {8'h07, 8'hAA, 8'hBB}: reg7=AA, then wrap so reg0=BB; err=0.
- status_in=8'h5C, frame {8'hFF, 8'h00}: second MISO byte=5C; err=0. Frame {8'h90, 8'h00}: reads 00, err=1; next frame start clears err.
- Assert rst_n=0 mid-write frame after byte {8'h01}, release, send {8'h33}, raise cs: no write occurs, regs all 0. Next full frame {8'h01, 8'h33} sets reg1=33.
- With SPI_REG_CTRL_ERRCNT_EN: three frames each accessing 7'h10 -> read 7'h7E returns 3; write {8'h7E, 8'h00} -> count 0. Without the macro, the read of 7'h7E returns 0 and sets err.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// SPI command/register-file controller (build option SPI_REG_CTRL_ERRCNT_EN adds a frame-error counter at 7'h7E).
// tx_data, wr_stb/wr_addr and reg_out update one clk after rx_valid; no backpressure, the slave paces every byte.
module spi_reg_ctrl #(
    parameter int          DATA_WIDTH = 8,
    parameter int          NUM_REGS   = 8,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           spi_cs_n,
    input  logic [DATA_WIDTH-1:0]          rx_data,
    input  logic                           rx_valid,
    input  logic                           tx_req,
    output logic [DATA_WIDTH-1:0]          tx_data,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic                           wr_stb,
    output logic [6:0]                     wr_addr,
    input  logic [DATA_WIDTH-1:0]          status_in,
    output logic                           err
);

    localparam logic [DATA_WIDTH-1:0] HDR   = DATA_WIDTH'(HEADER);
    localparam logic [6:0]            NREG7 = 7'(NUM_REGS);
    localparam logic [6:0]            LAST7 = 7'(NUM_REGS - 1);

    typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

    state_t                state, state_nxt;
    logic                  cs_meta, cs_s, cs_s_q;
    logic [1:0]            sync_live;
    logic                  armed;
    logic                  cs_fall, cs_rise;
    logic [6:0]            addr, addr_nxt;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] tx_nxt;
    logic                  err_nxt;
    logic                  wr_en;
    logic                  wr_stb_nxt;
    logic [6:0]            wr_addr_nxt;
    logic                  load_en;
    logic [6:0]            load_addr;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  rd_bad;
`ifdef SPI_REG_CTRL_ERRCNT_EN
    logic [7:0]            err_cnt;
    logic                  cnt_clr;
`else
    logic                  unused_tx_req;
    assign unused_tx_req = tx_req;
`endif

    function automatic logic [6:0] next_addr(input logic [6:0] a);
        if (a < LAST7)
            return a + 7'd1;
        else if (a == LAST7)
            return 7'd0;
        else
            return a;
    endfunction

    // Falling edges are only trusted once cs_s has carried a real high sample,
    // so a frame already in progress when reset releases is skipped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs_meta   <= 1'b1;
            cs_s      <= 1'b1;
            cs_s_q    <= 1'b1;
            sync_live <= 2'b00;
            armed     <= 1'b0;
        end else begin
            cs_meta   <= spi_cs_n;
            cs_s      <= cs_meta;
            cs_s_q    <= cs_s;
            sync_live <= {sync_live[0], 1'b1};
            if (sync_live[1] && cs_s)
                armed <= 1'b1;
        end
    end

    assign cs_fall = armed & cs_s_q & ~cs_s;
    assign cs_rise = ~cs_s_q & cs_s;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (cs_fall) state_nxt = CMD;
            CMD:  if (rx_valid) state_nxt = rx_data[DATA_WIDTH-1] ? RD : WR;
            default: state_nxt = state;
        endcase
        if (state != IDLE && cs_rise)
            state_nxt = IDLE;
    end

    always_comb begin
        load_en   = 1'b0;
        load_addr = addr;
        if (rx_valid) begin
            if (state == CMD && rx_data[DATA_WIDTH-1]) begin
                load_en   = 1'b1;
                load_addr = rx_data[6:0];
            end else if (state == RD) begin
                load_en   = 1'b1;
                load_addr = next_addr(addr);
            end
        end
    end

    always_comb begin
        rd_val = '0;
        rd_bad = 1'b0;
        if (load_addr < NREG7) begin
            for (int k = 0; k < NUM_REGS; k++)
                if (load_addr == 7'(k))
                    rd_val = regs[k];
        end else if (load_addr == 7'h7F) begin
            rd_val = status_in;
        end
`ifdef SPI_REG_CTRL_ERRCNT_EN
        else if (load_addr == 7'h7E) begin
            rd_val = DATA_WIDTH'(err_cnt);
        end
`endif
        else begin
            rd_bad = 1'b1;
        end
    end

    always_comb begin
        tx_nxt      = tx_data;
        err_nxt     = err;
        addr_nxt    = addr;
        wr_en       = 1'b0;
        wr_stb_nxt  = 1'b0;
        wr_addr_nxt = wr_addr;
`ifdef SPI_REG_CTRL_ERRCNT_EN
        cnt_clr     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    tx_nxt  = HDR;
                    err_nxt = 1'b0;
                end
            end
            CMD: begin
                if (rx_valid)
                    addr_nxt = rx_data[6:0];
            end
            WR: begin
                if (rx_valid) begin
                    addr_nxt = next_addr(addr);
                    if (addr < NREG7) begin
                        wr_en       = 1'b1;
                        wr_stb_nxt  = 1'b1;
                        wr_addr_nxt = addr;
                    end
`ifdef SPI_REG_CTRL_ERRCNT_EN
                    else if (addr == 7'h7E) begin
                        cnt_clr = 1'b1;
                    end
`endif
                    else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            RD: begin
                if (rx_valid)
                    addr_nxt = next_addr(addr);
            end
            default: ;
        endcase
        if (load_en) begin
            tx_nxt = rd_val;
            if (rd_bad)
                err_nxt = 1'b1;
        end
        // End of frame wins over a read load arriving in the same cycle.
        if (state != IDLE && cs_rise)
            tx_nxt = HDR;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr    <= '0;
            tx_data <= HDR;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            err     <= 1'b0;
        end else begin
            addr    <= addr_nxt;
            tx_data <= tx_nxt;
            wr_stb  <= wr_stb_nxt;
            wr_addr <= wr_addr_nxt;
            err     <= err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++)
                regs[k] <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < NUM_REGS; k++)
                if (addr == 7'(k))
                    regs[k] <= rx_data;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

`ifdef SPI_REG_CTRL_ERRCNT_EN
    // Counts frames that close with err set, plus tx_req seen while idle (underrun).
    always_ff @(posedge clk) begin
        if (!rst_n)
            err_cnt <= 8'd0;
        else if (cnt_clr)
            err_cnt <= 8'd0;
        else if (((state != IDLE && cs_rise && err_nxt) || (state == IDLE && tx_req))
                 && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end
`endif

endmodule
